// File: rtl/epb_wbm_bridge_sync.sv
// epb_wbm_bridge_sync: single-clock EPB slave to Wishbone classic master bridge.
// Each EPB chip-select falling edge launches exactly one WB cycle. Read data, or
// ERR_DATA on err/timeout, goes back to the host with a one-clock epb_rdy strobe.
// Ports:
//   wb_clk_i, wb_rst_n_i              clock, async active-low reset
//   epb_cs_n/oe_n/r_w_n/be_n/addr     EPB host control, address and byte enables
//   epb_data_i/epb_data_o             EPB write data in, read data out
//   epb_data_oe_n, epb_rdy            pad drive enable (active-low), completion strobe
//   wbm_*                             Wishbone classic master interface
//   err_cnt, busy                     saturating error/timeout count, not-idle flag
module epb_wbm_bridge_sync #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 25,
    parameter int          TIMEOUT    = 1023,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF,
    parameter int          ERRCNT_W   = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic                    epb_cs_n,
    input  logic                    epb_oe_n,
    input  logic                    epb_r_w_n,
    input  logic [DATA_WIDTH/8-1:0] epb_be_n,
    input  logic [ADDR_WIDTH-1:0]   epb_addr,
    input  logic [DATA_WIDTH-1:0]   epb_data_i,
    output logic [DATA_WIDTH-1:0]   epb_data_o,
    output logic                    epb_data_oe_n,
    output logic                    epb_rdy,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    output logic [ERRCNT_W-1:0]     err_cnt,
    output logic                    busy
);
    // A zero TIMEOUT still needs a 1-bit counter so the logic stays legal.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DATA_WIDTH-1:0] ERR_FILL = {(DATA_WIDTH / 32){ERR_DATA}};

    typedef enum logic [1:0] {IDLE, WB_REQ, RESP, HOLD} state_t;

    state_t        state, state_nxt;
    logic          cs_q;
    logic [TW-1:0] tcnt;
    logic          cs_fall, timed_out, done, fail;

    assign wbm_stb_o = wbm_cyc_o;

    always_comb begin
        cs_fall   = cs_q & ~epb_cs_n;
        timed_out = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT));
        done      = wbm_err_i | wbm_ack_i | timed_out;
        // err beats ack; ack beats a coincident timeout
        fail      = wbm_err_i | (timed_out & ~wbm_ack_i);
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = WB_REQ;
            WB_REQ:  if (done) state_nxt = RESP;
            RESP:    state_nxt = HOLD;
            HOLD:    if (epb_cs_n) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // a host that released cs_n mid-cycle has aborted, so it gets no strobe
        epb_rdy       = (state == RESP) && !epb_cs_n;
        epb_data_oe_n = !(!wbm_we_o && (state == RESP || state == HOLD) && !epb_oe_n && !epb_cs_n);
        busy          = state != IDLE;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cs_q       <= 1'b1;
            tcnt       <= '0;
            wbm_cyc_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= '0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            epb_data_o <= '0;
            err_cnt    <= '0;
        end else begin
            cs_q <= epb_cs_n;
            case (state)
                IDLE: if (cs_fall) begin
                    wbm_cyc_o <= 1'b1;
                    wbm_we_o  <= ~epb_r_w_n;
                    wbm_sel_o <= ~epb_be_n;
                    wbm_adr_o <= epb_addr;
                    wbm_dat_o <= epb_data_i;
                    tcnt      <= '0;
                end
                WB_REQ: begin
                    tcnt <= tcnt + 1'b1;
                    if (done) begin
                        wbm_cyc_o <= 1'b0;
                        if (fail) begin
                            epb_data_o <= ERR_FILL;
                            if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
                        end else if (!wbm_we_o) begin
                            epb_data_o <= wbm_dat_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_epb_wbm_bridge_sync.sv
// tb_epb_wbm_bridge_sync: directed table, corner sequences and random transactions vs a reference model.
module tb_epb_wbm_bridge_sync;
    localparam int DW = 32, AW = 25, TO = 8, EW = 2;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          epb_cs_n, epb_oe_n, epb_r_w_n;
    logic [3:0]    epb_be_n;
    logic [AW-1:0] epb_addr;
    logic [DW-1:0] epb_data_i, epb_data_o, wbm_dat_o, wbm_dat_i;
    logic          epb_data_oe_n, epb_rdy, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i, busy;
    logic [3:0]    wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [EW-1:0] err_cnt;

    epb_wbm_bridge_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO), .ERR_DATA(ERRD), .ERRCNT_W(EW)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .epb_cs_n(epb_cs_n), .epb_oe_n(epb_oe_n),
        .epb_r_w_n(epb_r_w_n), .epb_be_n(epb_be_n), .epb_addr(epb_addr), .epb_data_i(epb_data_i),
        .epb_data_o(epb_data_o), .epb_data_oe_n(epb_data_oe_n), .epb_rdy(epb_rdy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i), .err_cnt(err_cnt), .busy(busy)
    );

    typedef struct {
        bit          rw_n;
        logic [3:0]  be_n;
        logic [AW-1:0] addr;
        logic [31:0] data;
        int          lat;     // cyc cycle on which the slave answers, 0 = never
        bit          ack;
        bit          err;
        logic [31:0] rdat;
        bit          abort;   // host drops cs_n in the first WB_REQ cycle
        int          ecyc;
        int          erdy;
        logic [31:0] edat;
        int          ecnt;
    } vec_t;

    int passed = 0, total = 0;
    logic [31:0] m_data;
    int m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(bit rw_n, logic [3:0] be_n, logic [AW-1:0] addr, logic [31:0] data,
                                int lat, bit ack, bit err, logic [31:0] rdat, bit abort,
                                int ecyc, int erdy, logic [31:0] edat, int ecnt);
        vec_t v;
        v.rw_n = rw_n; v.be_n = be_n; v.addr = addr; v.data = data; v.lat = lat; v.ack = ack;
        v.err = err; v.rdat = rdat; v.abort = abort; v.ecyc = ecyc; v.erdy = erdy; v.edat = edat; v.ecnt = ecnt;
        return v;
    endfunction

    // Transaction-level model: outcome is decided by when (if ever) the slave answers.
    task automatic model(inout vec_t v);
        bit to;
        to = (v.lat == 0) || (v.lat > TO + 1);
        v.ecyc = to ? TO + 1 : v.lat;
        if (to || v.err) begin
            m_data = ERRD;
            if (m_cnt < (1 << EW) - 1) m_cnt++;
        end else if (v.rw_n) begin
            m_data = v.rdat;
        end
        v.erdy = v.abort ? 0 : 1;
        v.edat = m_data;
        v.ecnt = m_cnt;
    endtask

    // Entered and left on a falling clock edge with cs_n having been high for one clock.
    task automatic apply(input vec_t v, input string tag, output int oc, output int orr);
        int ncyc = 0, nrdy = 0, noe = 0, post = 0, first = -1;
        bit fin = 0;
        logic [AW-1:0] ca;
        logic cw;
        logic [3:0] cs;
        logic [31:0] cd;
        epb_cs_n = 0; epb_r_w_n = v.rw_n; epb_oe_n = ~v.rw_n; epb_be_n = v.be_n;
        epb_addr = v.addr; epb_data_i = v.data;
        for (int t = 0; t < 60 && !fin; t++) begin
            @(negedge clk);
            wbm_ack_i = 0; wbm_err_i = 0; wbm_dat_i = $urandom;
            if (ncyc > 0 && !wbm_cyc_o) post++;
            if (post == 3) fin = 1;
            if (wbm_cyc_o) begin
                ncyc++;
                if (ncyc == 1) begin
                    first = t; ca = wbm_adr_o; cw = wbm_we_o; cs = wbm_sel_o; cd = wbm_dat_o;
                end
                if (ncyc == v.lat) begin
                    wbm_ack_i = v.ack; wbm_err_i = v.err; wbm_dat_i = v.rdat;
                end
            end
            if (epb_rdy) nrdy++;
            if (!epb_data_oe_n) noe++;
            if ((v.abort && ncyc == 1) || post == 2) epb_cs_n = 1;
        end
        chk({tag, " finished"}, 64'(fin), 64'(1));
        chk({tag, " cyc latency"}, 64'(first), 64'(0));
        chk({tag, " adr"}, ca, v.addr);
        chk({tag, " we"}, cw, 1'(~v.rw_n));
        chk({tag, " sel"}, cs, 4'(~v.be_n));
        chk({tag, " dat_o"}, cd, v.data);
        chk({tag, " cyc clocks"}, 64'(ncyc), 64'(v.ecyc));
        chk({tag, " rdy pulses"}, 64'(nrdy), 64'(v.erdy));
        chk({tag, " oe_n low clocks"}, 64'(noe), 64'((v.rw_n && !v.abort) ? 2 : 0));
        chk({tag, " epb_data_o"}, epb_data_o, v.edat);
        chk({tag, " err_cnt"}, err_cnt, 64'(v.ecnt));
        chk({tag, " busy"}, busy, 0);
        oc = (ncyc > 0) ? 1 : 0;
        orr = nrdy;
    endtask

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int oc, orr, sc, sr;
        epb_cs_n = 1; epb_oe_n = 1; epb_r_w_n = 1; epb_be_n = 0; epb_addr = 0; epb_data_i = 0;
        wbm_dat_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
        tbl[0] = mk(1, 4'h0,    25'h12345,   32'h0,        3,  1, 0, 32'hCAFEF00D, 0, 3, 1, 32'hCAFEF00D, 0);
        tbl[1] = mk(0, 4'b1100, 25'h00ABC,   32'hA5A5A5A5, 1,  1, 0, 32'h12121212, 0, 1, 1, 32'hCAFEF00D, 0);
        tbl[2] = mk(1, 4'h0,    25'h1FFFFFF, 32'h0,        0,  0, 0, 32'h0,        0, 9, 1, ERRD,         1);
        tbl[3] = mk(1, 4'h0,    25'h00010,   32'h0,        2,  1, 1, 32'h11111111, 0, 2, 1, ERRD,         2);
        tbl[4] = mk(1, 4'b0101, 25'h00020,   32'h0,        9,  1, 0, 32'h0BADCAFE, 0, 9, 1, 32'h0BADCAFE, 2);
        tbl[5] = mk(1, 4'h0,    25'h00030,   32'h0,        4,  1, 0, 32'h13572468, 1, 4, 0, 32'h13572468, 2);
        tbl[6] = mk(0, 4'h0,    25'h00040,   32'h5A5A5A5A, 2,  0, 1, 32'h0,        0, 2, 1, ERRD,         3);
        tbl[7] = mk(1, 4'h0,    25'h00050,   32'h0,        0,  0, 0, 32'h0,        0, 9, 1, ERRD,         3);
        tbl[8] = mk(0, 4'b1110, 25'h00060,   32'h01234567, 10, 1, 0, 32'h77777777, 0, 9, 1, ERRD,         3);

        #12;
        chk("reset cyc", wbm_cyc_o, 0);
        chk("reset stb", wbm_stb_o, 0);
        chk("reset we", wbm_we_o, 0);
        chk("reset sel", wbm_sel_o, 0);
        chk("reset adr", wbm_adr_o, 0);
        chk("reset dat_o", wbm_dat_o, 0);
        chk("reset epb_data_o", epb_data_o, 0);
        chk("reset oe_n", epb_data_oe_n, 1);
        chk("reset rdy", epb_rdy, 0);
        chk("reset err_cnt", err_cnt, 0);
        chk("reset busy", busy, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i), oc, orr);
        m_data = tbl[8].edat; m_cnt = tbl[8].ecnt;

        sc = 0; sr = 0;
        for (int i = 0; i < 5; i++) begin
            v = mk(1, 4'h0, 25'(i), 0, i + 1, 1, 0, $urandom, 0, 0, 0, 0, 0);
            model(v);
            apply(v, $sformatf("b2b%0d", i), oc, orr);
            sc += oc; sr += orr;
        end
        chk("b2b wb cycles", 64'(sc), 64'(5));
        chk("b2b rdy pulses", 64'(sr), 64'(5));

        // reset in the middle of WB_REQ must drop cyc without a clock edge
        epb_cs_n = 0; epb_r_w_n = 1; epb_oe_n = 0;
        repeat (3) @(negedge clk);
        chk("pre-reset cyc", wbm_cyc_o, 1);
        chk("pre-reset err_cnt", err_cnt, 64'(m_cnt));
        #2 rst_n = 0;
        #1;
        chk("async reset cyc", wbm_cyc_o, 0);
        chk("async reset stb", wbm_stb_o, 0);
        chk("async reset busy", busy, 0);
        chk("async reset rdy", epb_rdy, 0);
        chk("async reset err_cnt", err_cnt, 0);
        chk("async reset epb_data_o", epb_data_o, 0);
        epb_cs_n = 1;
        @(negedge clk);
        chk("reset held rdy", epb_rdy, 0);
        rst_n = 1;
        m_data = 0; m_cnt = 0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            v = mk(1, 4'h0, 25'(100 + i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            model(v);
            apply(v, $sformatf("sat%0d", i), oc, orr);
        end

        for (int i = 0; i < 25; i++) begin
            int k;
            v = mk($urandom_range(0, 1), 4'($urandom), 25'($urandom), $urandom,
                   $urandom_range(0, 11), 0, 0, $urandom, $urandom_range(0, 4) == 0, 0, 0, 0, 0);
            k = $urandom_range(0, 2);
            if (v.lat > 0) begin
                v.ack = (k != 1);
                v.err = (k != 0);
            end
            model(v);
            apply(v, $sformatf("rnd%0d", i), oc, orr);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
